// File: rtl/lpif_align_pkg.sv
// Shared types and constants for the LPIF asym1 half-rate receive alignment.
// State encoding, marker pattern and debug status field offsets.
package lpif_align_pkg;

  typedef enum logic [2:0] {
    OFF    = 3'd0,
    HUNT   = 3'd1,
    VERIFY = 3'd2,
    LOCKED = 3'd3
  } state_t;

  localparam logic [1:0] MRK_PATTERN = 2'b10;

  localparam int unsigned DBG_STATE_LSB = 29;
  localparam int unsigned DBG_LOCK_BIT  = 28;
  localparam int unsigned DBG_GOOD_LSB  = 24;
  localparam int unsigned DBG_MISS_LSB  = 20;
  localparam int unsigned DBG_ERR_LSB   = 0;

endpackage

// File: rtl/lpif_rx_beat_check.sv
// Combinational good-beat decode: strobe on channel 0 plus
// the {marker1,marker0} pattern on both channels.
module lpif_rx_beat_check
  import lpif_align_pkg::*;
#(
  parameter int unsigned PHY_WIDTH = 80,
  parameter int unsigned STB_POS   = 1,
  parameter int unsigned MRK0_POS  = 39,
  parameter int unsigned MRK1_POS  = 79
) (
  input  logic [PHY_WIDTH-1:0] rx_phy0,
  input  logic [PHY_WIDTH-1:0] rx_phy1,
  output logic                 good
);

  logic stb_ok;
  logic mrk0_ok;
  logic mrk1_ok;

  assign stb_ok  = rx_phy0[STB_POS];
  assign mrk0_ok = ({rx_phy0[MRK1_POS], rx_phy0[MRK0_POS]} == MRK_PATTERN);
  assign mrk1_ok = ({rx_phy1[MRK1_POS], rx_phy1[MRK0_POS]} == MRK_PATTERN);
  assign good    = stb_ok & mrk0_ok & mrk1_ok;

endmodule

// File: rtl/lpif_asym1_half_rx_align.sv
// Receive alignment checker: word lock FSM with hysteresis,
// registered aligned data, saturating error counter and debug word.
module lpif_asym1_half_rx_align
  import lpif_align_pkg::*;
#(
  parameter int unsigned PHY_WIDTH     = 80,
  parameter int unsigned STB_POS       = 1,
  parameter int unsigned MRK0_POS      = 39,
  parameter int unsigned MRK1_POS      = 79,
  parameter int unsigned LOCK_CNT      = 4,
  parameter int unsigned UNLOCK_CNT    = 2,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_wr,
  input  logic                     rst_wr_n,
  input  logic                     rx_online,
  input  logic                     clr_err,
  input  logic [PHY_WIDTH-1:0]     rx_phy0,
  input  logic [PHY_WIDTH-1:0]     rx_phy1,
  output logic [2*PHY_WIDTH-1:0]   rx_data,
  output logic                     rx_data_vld,
  output logic                     rx_locked,
  output logic [ERR_CNT_WIDTH-1:0] align_err_cnt,
  output logic [31:0]              rx_align_debug_status
);

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

  state_t                   state_q;
  state_t                   state_d;
  logic [3:0]               good_q;
  logic [3:0]               good_d;
  logic [3:0]               miss_q;
  logic [3:0]               miss_d;
  logic [ERR_CNT_WIDTH-1:0] err_q;
  logic                     err_inc;
  logic                     good;

  lpif_rx_beat_check #(
    .PHY_WIDTH (PHY_WIDTH),
    .STB_POS   (STB_POS),
    .MRK0_POS  (MRK0_POS),
    .MRK1_POS  (MRK1_POS)
  ) u_beat_check (
    .rx_phy0 (rx_phy0),
    .rx_phy1 (rx_phy1),
    .good    (good)
  );

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    miss_d  = miss_q;
    err_inc = 1'b0;
    if (!rx_online) begin
      state_d = OFF;
      good_d  = '0;
      miss_d  = '0;
    end else begin
      unique case (1'b1)
        (state_q == OFF): begin
          state_d = HUNT;
        end
        (state_q == HUNT): begin
          if (good) begin
            good_d  = 4'd1;
            state_d = (LOCK_C == 4'd1) ? LOCKED : VERIFY;
          end
        end
        (state_q == VERIFY): begin
          if (good) begin
            good_d = good_q + 4'd1;
            if (good_d == LOCK_C) state_d = LOCKED;
          end else begin
            state_d = HUNT;
            good_d  = '0;
          end
        end
        (state_q == LOCKED): begin
          if (good) begin
            miss_d = '0;
          end else begin
            err_inc = 1'b1;
            miss_d  = miss_q + 4'd1;
            if (miss_d == UNLOCK_C) begin
              state_d = HUNT;
              good_d  = '0;
              miss_d  = '0;
            end
          end
        end
        default: begin
          state_d = OFF;
          good_d  = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q <= OFF;
      good_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
    end
  end

  // Saturates at all-ones; clear takes priority over a bad beat.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      err_q <= '0;
    end else if (clr_err) begin
      err_q <= '0;
    end else if (err_inc && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      rx_data     <= '0;
      rx_data_vld <= 1'b0;
    end else begin
      rx_data     <= {rx_phy1, rx_phy0};
      rx_data_vld <= (state_q == LOCKED) & rx_online & good;
    end
  end

  assign rx_locked     = (state_q == LOCKED);
  assign align_err_cnt = err_q;

  always_comb begin
    rx_align_debug_status = '0;
    rx_align_debug_status[DBG_STATE_LSB +: 3] = state_q;
    rx_align_debug_status[DBG_LOCK_BIT]       = rx_locked;
    rx_align_debug_status[DBG_GOOD_LSB +: 4]  = good_q;
    rx_align_debug_status[DBG_MISS_LSB +: 4]  = miss_q;
    rx_align_debug_status[DBG_ERR_LSB +: 16]  = 16'(err_q);
  end

endmodule

// File: tb/tb_lpif_asym1_half_rx_align.sv
// Directed bench for lpif_asym1_half_rx_align with a lock model;
// a second instance uses a 2-bit error counter to show saturation.
module tb_lpif_asym1_half_rx_align;

  logic         clk_wr = 1'b0;
  logic         rst_wr_n = 1'b1;
  logic         rx_online = 1'b0;
  logic         clr_err = 1'b0;
  logic [79:0]  rx_phy0 = '0;
  logic [79:0]  rx_phy1 = '0;

  logic [159:0] rx_data;
  logic         rx_data_vld;
  logic         rx_locked;
  logic [15:0]  align_err_cnt;
  logic [31:0]  dbg;

  logic [159:0] s_data;
  logic         s_vld;
  logic         s_locked;
  logic [1:0]   s_err;
  logic [31:0]  s_dbg;

  int checks = 0;
  int failures = 0;

  lpif_asym1_half_rx_align dut (
    .clk_wr                (clk_wr),
    .rst_wr_n              (rst_wr_n),
    .rx_online             (rx_online),
    .clr_err               (clr_err),
    .rx_phy0               (rx_phy0),
    .rx_phy1               (rx_phy1),
    .rx_data               (rx_data),
    .rx_data_vld           (rx_data_vld),
    .rx_locked             (rx_locked),
    .align_err_cnt         (align_err_cnt),
    .rx_align_debug_status (dbg)
  );

  lpif_asym1_half_rx_align #(.ERR_CNT_WIDTH(2)) dut_s (
    .clk_wr                (clk_wr),
    .rst_wr_n              (rst_wr_n),
    .rx_online             (rx_online),
    .clr_err               (clr_err),
    .rx_phy0               (rx_phy0),
    .rx_phy1               (rx_phy1),
    .rx_data               (s_data),
    .rx_data_vld           (s_vld),
    .rx_locked             (s_locked),
    .align_err_cnt         (s_err),
    .rx_align_debug_status (s_dbg)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Model: st 0=off 1=hunt 2=verify 3=locked; counts kept as plain ints.
  int           m_st = 0;
  int           m_gc = 0;
  int           m_mc = 0;
  int           m_err = 0;
  int           m_errs = 0;
  logic [159:0] m_data = '0;
  logic         m_vld = 1'b0;

  function automatic bit is_good(input logic [79:0] p0, input logic [79:0] p1);
    return p0[1] && p0[79] && !p0[39] && p1[79] && !p1[39];
  endfunction

  always @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      m_st = 0; m_gc = 0; m_mc = 0; m_err = 0; m_errs = 0;
      m_data = '0; m_vld = 1'b0;
    end else begin
      bit g;
      g = is_good(rx_phy0, rx_phy1);
      m_data = {rx_phy1, rx_phy0};
      m_vld = (m_st == 3) && rx_online && g;
      if (!rx_online) begin
        m_st = 0; m_gc = 0; m_mc = 0;
      end else if (m_st == 0) begin
        m_st = 1;
      end else if (m_st == 1) begin
        if (g) begin m_gc = 1; m_st = 2; end
      end else if (m_st == 2) begin
        if (g) begin
          m_gc = m_gc + 1;
          if (m_gc == 4) m_st = 3;
        end else begin
          m_st = 1; m_gc = 0;
        end
      end else begin
        if (g) m_mc = 0;
        else begin
          m_mc = m_mc + 1;
          if (m_err < 65535) m_err = m_err + 1;
          if (m_errs < 3) m_errs = m_errs + 1;
          if (m_mc == 2) begin m_st = 1; m_gc = 0; m_mc = 0; end
        end
      end
      if (clr_err) begin m_err = 0; m_errs = 0; end
    end
  end

  function automatic logic [31:0] exp_dbg(input int e);
    logic [2:0] st3;
    logic [3:0] g4;
    logic [3:0] m4;
    logic [15:0] e16;
    st3 = m_st[2:0]; g4 = m_gc[3:0]; m4 = m_mc[3:0]; e16 = e[15:0];
    return {st3, (m_st == 3), g4, m4, 4'h0, e16};
  endfunction

  always @(negedge clk_wr) begin
    chk("data", rx_data, m_data);
    chk("vld", rx_data_vld, m_vld);
    chk("locked", rx_locked, m_st == 3);
    chk("err", align_err_cnt, m_err);
    chk("dbg", dbg, exp_dbg(m_err));
    chk("s_data", s_data, m_data);
    chk("s_vld", s_vld, m_vld);
    chk("s_err", s_err, m_errs);
    chk("s_dbg", s_dbg, exp_dbg(m_errs));
    chk("s_locked", s_locked, m_st == 3);
  end

  // kind: 0 good, 1 phy1[79]=0, 2 phy0[1]=0, 3 phy0[39]=1
  task automatic beat(input int kind);
    logic [79:0] a;
    logic [79:0] b;
    a = {$urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom};
    a[1] = 1'b1; a[39] = 1'b0; a[79] = 1'b1;
    b[39] = 1'b0; b[79] = 1'b1;
    if (kind == 1) b[79] = 1'b0;
    if (kind == 2) a[1] = 1'b0;
    if (kind == 3) a[39] = 1'b1;
    rx_phy0 = a;
    rx_phy1 = b;
    @(posedge clk_wr);
    #1;
  endtask

  initial begin
    #1 rst_wr_n = 1'b0;
    repeat (2) @(posedge clk_wr);
    #1;
    chk("rst_locked", rx_locked, 1'b0);
    chk("rst_dbg", dbg, 32'h0);
    chk("rst_data", rx_data, 160'h0);
    rst_wr_n = 1'b1;

    // 1: acquire lock
    rx_online = 1'b1;
    beat(1);
    chk("t1_hunt", dbg[31:29], 3'd1);
    repeat (3) beat(0);
    chk("t1_not_yet", rx_locked, 1'b0);
    beat(0);
    chk("t1_locked", rx_locked, 1'b1);
    chk("t1_no_vld", rx_data_vld, 1'b0);
    beat(0);
    chk("t1_vld", rx_data_vld, 1'b1);

    // 2: single miss keeps lock
    beat(1);
    chk("t2_vld0", rx_data_vld, 1'b0);
    chk("t2_err", align_err_cnt, 16'd1);
    chk("t2_miss", dbg[23:20], 4'd1);
    beat(0);
    chk("t2_miss0", dbg[23:20], 4'd0);
    chk("t2_lock", rx_locked, 1'b1);

    // 3: two misses drop lock
    beat(1);
    beat(1);
    chk("t3_unlock", rx_locked, 1'b0);
    chk("t3_hunt", dbg[31:29], 3'd1);
    chk("t3_err", align_err_cnt, 16'd3);

    // 4: verify interrupted
    repeat (3) beat(0);
    chk("t4_gc3", dbg[27:24], 4'd3);
    chk("t4_verify", dbg[31:29], 3'd2);
    beat(2);
    chk("t4_hunt", dbg[31:29], 3'd1);
    chk("t4_gc0", dbg[27:24], 4'd0);
    repeat (3) beat(0);
    chk("t4_relock_no", rx_locked, 1'b0);
    beat(3);
    repeat (4) beat(0);
    chk("t4_relock", rx_locked, 1'b1);

    // 5: offline, then clear with a bad beat
    beat(0);
    rx_online = 1'b0;
    beat(0);
    chk("t5_off", dbg[31:29], 3'd0);
    chk("t5_vld0", rx_data_vld, 1'b0);
    chk("t5_err_held", align_err_cnt, 16'd3);
    rx_online = 1'b1;
    beat(0);
    repeat (4) beat(0);
    chk("t5_lock", rx_locked, 1'b1);
    clr_err = 1'b1;
    beat(1);
    clr_err = 1'b0;
    chk("t5_clr", align_err_cnt, 16'd0);
    chk("t5_s_clr", s_err, 2'd0);
    beat(0);

    // 6: saturation on the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      beat(1);
      beat(0);
    end
    chk("t6_sat", s_err, 2'd3);
    chk("t6_wide", align_err_cnt, 16'd5);
    chk("t6_lock", rx_locked, 1'b1);

    // asynchronous reset mid-operation
    #2 rst_wr_n = 1'b0;
    #1;
    chk("ar_err", align_err_cnt, 16'd0);
    chk("ar_lock", rx_locked, 1'b0);
    chk("ar_data", rx_data, 160'h0);
    chk("ar_sdbg", s_dbg, 32'h0);
    @(posedge clk_wr);
    #1 rst_wr_n = 1'b1;
    repeat (3) beat(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
